// File: rtl/mips32i_mem_pkg.sv
// Shared types for the mips32i memory arbiter.
// FSM states, grant-owner encoding and size codes.
package mips32i_mem_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DATA,
    S_DONE,
    S_ERR
  } state_t;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_t;

  localparam logic [1:0] SIZE_WORD = 2'b11;

endpackage

// File: rtl/mips32i_wait_timer.sv
// Wait-cycle counter for a pending memory access.
// clk/rst, clr (grant), en (waiting), expired (last allowed cycle).
module mips32i_wait_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] CNT_MAX  = W'(TIMEOUT);
  localparam logic [W-1:0] CNT_LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && cnt != CNT_MAX) begin
      cnt <= cnt + W'(1);
    end
  end

  // cnt holds the number of already-elapsed wait cycles, so
  // the current cycle is the TIMEOUT-th one when cnt hits LAST.
  assign expired = en && (cnt >= CNT_LAST);

endmodule

// File: rtl/mips32i_mem_arbiter.sv
// Arbitrates fetch and load/store ports onto one memory port.
// Ports: if_* fetch, d_* data, mem_* memory, cpu_stall, bus_err.
module mips32i_mem_arbiter
  import mips32i_mem_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_inst,
  output logic        if_done,
  input  logic        d_rd_en,
  input  logic        d_wt_en,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [1:0]  d_size,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        bus_err,
  output logic        cpu_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_size,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  state_t state, state_n;
  owner_t owner;

  logic d_req;
  logic grant_fetch;
  logic grant_data;
  logic waiting;
  logic expired;
  logic abort;
  logic finish;

  assign d_req = d_rd_en | d_wt_en;

  mips32i_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (grant_fetch | grant_data),
    .en     (waiting),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n     = state;
    grant_fetch = 1'b0;
    grant_data  = 1'b0;
    waiting     = 1'b0;
    unique case (state)
      S_IDLE: begin
        // owner doubles as last_grant: on a tie the port
        // that did not win last time is served.
        if (d_req && (!if_req || owner == OWN_FETCH)) begin
          state_n    = S_DATA;
          grant_data = 1'b1;
        end else if (if_req) begin
          state_n     = S_FETCH;
          grant_fetch = 1'b1;
        end
      end
      S_FETCH, S_DATA: begin
        waiting = 1'b1;
        if (mem_ack)      state_n = S_DONE;
        else if (expired) state_n = S_ERR;
      end
      S_DONE, S_ERR: state_n = S_IDLE;
      default:       state_n = S_IDLE;
    endcase
  end

  assign finish = waiting && mem_ack;
  assign abort  = waiting && !mem_ack && expired;

  always_ff @(posedge clk) begin
    if (rst) begin
      owner     <= OWN_FETCH;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_size  <= '0;
      if_inst   <= '0;
      d_rdata   <= '0;
    end else begin
      if (grant_data) begin
        owner     <= OWN_DATA;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
        mem_size  <= d_size;
        mem_we    <= d_wt_en;
      end else if (grant_fetch) begin
        owner     <= OWN_FETCH;
        mem_addr  <= if_addr;
        mem_wdata <= '0;
        mem_size  <= SIZE_WORD;
        mem_we    <= 1'b0;
      end
      if (finish) begin
        if (owner == OWN_FETCH) if_inst <= mem_rdata;
        else if (!mem_we)       d_rdata <= mem_rdata;
      end
      if (abort) begin
        if (owner == OWN_FETCH) if_inst <= '0;
        else                    d_rdata <= '0;
      end
    end
  end

  logic fin_state;
  assign fin_state = (state == S_DONE) || (state == S_ERR);

  assign mem_req   = (state == S_FETCH) || (state == S_DATA);
  assign if_done   = fin_state && (owner == OWN_FETCH);
  assign d_done    = fin_state && (owner == OWN_DATA);
  assign bus_err   = (state == S_ERR);
  assign cpu_stall = (if_req & ~if_done) | (d_req & ~d_done);

endmodule

// File: tb/tb_mips32i_mem_arbiter.sv
// Directed self-checking bench for mips32i_mem_arbiter.
// Runs with TIMEOUT = 4 so the abort path is reachable quickly.
module tb_mips32i_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_inst;
  logic        if_done;
  logic        d_rd_en;
  logic        d_wt_en;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [1:0]  d_size;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        bus_err;
  logic        cpu_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  mem_size;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int checks = 0;
  int failures = 0;

  mips32i_mem_arbiter #(.TIMEOUT(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_inst  (if_inst),
    .if_done  (if_done),
    .d_rd_en  (d_rd_en),
    .d_wt_en  (d_wt_en),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_size   (d_size),
    .d_rdata  (d_rdata),
    .d_done   (d_done),
    .bus_err  (bus_err),
    .cpu_stall(cpu_stall),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_size (mem_size),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({mem_req, mem_we, mem_size} !== 4'b0) begin
      failures++;
      $display("FAIL reset_ctl: got %b want 0000",
               {mem_req, mem_we, mem_size});
    end
    checks++;
    if ({mem_addr, mem_wdata} !== 64'h0) begin
      failures++;
      $display("FAIL reset_bus: got %h want 0",
               {mem_addr, mem_wdata});
    end
    checks++;
    if ({if_inst, d_rdata} !== 64'h0) begin
      failures++;
      $display("FAIL reset_rdata: got %h want 0",
               {if_inst, d_rdata});
    end
    checks++;
    if ({if_done, d_done, bus_err, cpu_stall} !== 4'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b want 0000",
               {if_done, d_done, bus_err, cpu_stall});
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_fetch();
    if_req  = 1'b1;
    if_addr = 32'h0000_0040;
    step();
    checks++;
    if ({mem_req, mem_we, mem_size, cpu_stall} !== 5'b10111) begin
      failures++;
      $display("FAIL fetch_req: got %b want 10111",
               {mem_req, mem_we, mem_size, cpu_stall});
    end
    checks++;
    if (mem_addr !== 32'h0000_0040) begin
      failures++;
      $display("FAIL fetch_addr: got %h want 00000040", mem_addr);
    end
    mem_ack   = 1'b1;
    mem_rdata = 32'h8C22_0004;
    step();
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    checks++;
    if ({if_done, d_done, bus_err, cpu_stall, mem_req} !== 5'b10000) begin
      failures++;
      $display("FAIL fetch_done: got %b want 10000",
               {if_done, d_done, bus_err, cpu_stall, mem_req});
    end
    checks++;
    if (if_inst !== 32'h8C22_0004) begin
      failures++;
      $display("FAIL fetch_inst: got %h want 8c220004", if_inst);
    end
    step();
    if_req = 1'b0;
    checks++;
    if ({if_done, mem_req} !== 2'b00) begin
      failures++;
      $display("FAIL fetch_idle: got %b want 00", {if_done, mem_req});
    end
  endtask

  task automatic test_alternation();
    logic exp_d;
    rst = 1'b1;
    step();
    rst     = 1'b0;
    if_req  = 1'b1;
    if_addr = 32'h0000_0300;
    d_rd_en = 1'b1;
    d_addr  = 32'h0000_0100;
    d_size  = 2'b11;
    for (int i = 0; i < 4; i++) begin
      exp_d = (i % 2 == 0);
      step();
      checks++;
      if (mem_addr !== (exp_d ? 32'h100 : 32'h300)) begin
        failures++;
        $display("FAIL alt_grant%0d: got %h want %h", i, mem_addr,
                 exp_d ? 32'h100 : 32'h300);
      end
      mem_ack   = 1'b1;
      mem_rdata = 32'h0000_1000 + i;
      step();
      mem_ack = 1'b0;
      checks++;
      if ({d_done, if_done} !== {exp_d, ~exp_d}) begin
        failures++;
        $display("FAIL alt_done%0d: got %b want %b", i,
                 {d_done, if_done}, {exp_d, ~exp_d});
      end
      checks++;
      if ((exp_d ? d_rdata : if_inst) !== 32'h0000_1000 + i) begin
        failures++;
        $display("FAIL alt_data%0d: got %h want %h", i,
                 exp_d ? d_rdata : if_inst, 32'h0000_1000 + i);
      end
      step();
    end
    if_req  = 1'b0;
    d_rd_en = 1'b0;
    step();
  endtask

  task automatic test_store_wait();
    d_wt_en = 1'b1;
    d_addr  = 32'h0000_0200;
    d_wdata = 32'hDEAD_BEEF;
    d_size  = 2'b11;
    step();
    d_wdata = 32'h0;
    for (int w = 0; w < 4; w++) begin
      checks++;
      if ({mem_req, mem_we, mem_size, d_done, cpu_stall} !== 6'b111101 ||
          mem_wdata !== 32'hDEAD_BEEF || mem_addr !== 32'h200) begin
        failures++;
        $display("FAIL store_wait%0d: got %b/%h/%h want 111101/deadbeef/200",
                 w, {mem_req, mem_we, mem_size, d_done, cpu_stall},
                 mem_wdata, mem_addr);
      end
      if (w == 3) mem_ack = 1'b1;
      step();
    end
    mem_ack = 1'b0;
    checks++;
    if ({d_done, bus_err, mem_req, cpu_stall} !== 4'b1000) begin
      failures++;
      $display("FAIL store_done: got %b want 1000",
               {d_done, bus_err, mem_req, cpu_stall});
    end
    checks++;
    if (d_rdata !== 32'h0000_1002) begin
      failures++;
      $display("FAIL store_rdata: got %h want 00001002", d_rdata);
    end
    step();
    d_wt_en = 1'b0;
    checks++;
    if (d_done !== 1'b0) begin
      failures++;
      $display("FAIL store_pulse: got %b want 0", d_done);
    end
  endtask

  task automatic test_timeout();
    d_rd_en = 1'b1;
    d_addr  = 32'h0000_0180;
    for (int w = 0; w < 4; w++) begin
      step();
      checks++;
      if ({mem_req, d_done, bus_err} !== 3'b100) begin
        failures++;
        $display("FAIL tmo_wait%0d: got %b want 100", w,
                 {mem_req, d_done, bus_err});
      end
    end
    step();
    checks++;
    if ({mem_req, d_done, bus_err} !== 3'b011) begin
      failures++;
      $display("FAIL tmo_err: got %b want 011",
               {mem_req, d_done, bus_err});
    end
    checks++;
    if (d_rdata !== 32'h0) begin
      failures++;
      $display("FAIL tmo_rdata: got %h want 0", d_rdata);
    end
    mem_ack   = 1'b1;
    mem_rdata = 32'hFFFF_0000;
    step();
    d_rd_en = 1'b0;
    step();
    checks++;
    if ({mem_req, d_done, bus_err} !== 3'b000 || d_rdata !== 32'h0) begin
      failures++;
      $display("FAIL tmo_late_ack: got %b/%h want 000/0",
               {mem_req, d_done, bus_err}, d_rdata);
    end
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    step();
  endtask

  task automatic test_reset_mid();
    d_rd_en = 1'b1;
    d_addr  = 32'h0000_01C0;
    step();
    step();
    checks++;
    if (mem_req !== 1'b1) begin
      failures++;
      $display("FAIL rmid_req: got %b want 1", mem_req);
    end
    rst = 1'b1;
    step();
    rst     = 1'b0;
    d_rd_en = 1'b0;
    checks++;
    if ({mem_req, d_done, if_done, bus_err} !== 4'b0000) begin
      failures++;
      $display("FAIL rmid_abort: got %b want 0000",
               {mem_req, d_done, if_done, bus_err});
    end
    step();
    checks++;
    if ({mem_req, d_done} !== 2'b00) begin
      failures++;
      $display("FAIL rmid_nodone: got %b want 00", {mem_req, d_done});
    end
    if_req  = 1'b1;
    if_addr = 32'h0000_0044;
    step();
    checks++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h44}) begin
      failures++;
      $display("FAIL rmid_fetch: got %b/%h want 1/44", mem_req, mem_addr);
    end
    mem_ack   = 1'b1;
    mem_rdata = 32'h2408_0001;
    step();
    mem_ack = 1'b0;
    checks++;
    if ({if_done, bus_err} !== 2'b10 || if_inst !== 32'h2408_0001) begin
      failures++;
      $display("FAIL rmid_fdone: got %b/%h want 10/24080001",
               {if_done, bus_err}, if_inst);
    end
    step();
    if_req = 1'b0;
  endtask

  task automatic test_rd_wt_both();
    d_rd_en = 1'b1;
    d_wt_en = 1'b1;
    d_addr  = 32'h0000_0240;
    d_wdata = 32'h1234_5678;
    checks++;
    if ({cpu_stall, mem_req} !== 2'b10) begin
      failures++;
      $display("FAIL both_stall0: got %b want 10", {cpu_stall, mem_req});
    end
    step();
    checks++;
    if ({mem_req, mem_we, cpu_stall} !== 3'b111 ||
        mem_wdata !== 32'h1234_5678) begin
      failures++;
      $display("FAIL both_write: got %b/%h want 111/12345678",
               {mem_req, mem_we, cpu_stall}, mem_wdata);
    end
    mem_ack   = 1'b1;
    mem_rdata = 32'hAAAA_5555;
    step();
    mem_ack = 1'b0;
    checks++;
    if ({d_done, cpu_stall, bus_err} !== 3'b100 || d_rdata !== 32'h0) begin
      failures++;
      $display("FAIL both_done: got %b/%h want 100/0",
               {d_done, cpu_stall, bus_err}, d_rdata);
    end
    step();
    d_rd_en = 1'b0;
    d_wt_en = 1'b0;
    step();
  endtask

  initial begin
    rst       = 1'b1;
    if_req    = 1'b0;
    if_addr   = '0;
    d_rd_en   = 1'b0;
    d_wt_en   = 1'b0;
    d_addr    = '0;
    d_wdata   = '0;
    d_size    = '0;
    mem_rdata = '0;
    mem_ack   = 1'b0;
    test_reset();
    test_fetch();
    test_alternation();
    test_store_wait();
    test_timeout();
    test_reset_mid();
    test_rd_wt_both();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
